// File: rtl/wbu_pkg.sv
// Shared encodings for the write-back unit: result-select codes, load funct3 codes,
// FSM states and the write-strobe bundle.
package wbu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned CNT_W = 64;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;

  typedef enum logic [SEL_W-1:0] {
    SEL_NONE   = 3'd0,
    SEL_ALU    = 3'd1,
    SEL_IMME   = 3'd2,
    SEL_PC     = 3'd3,
    SEL_PC_SEQ = 3'd4,
    SEL_CSR    = 3'd5,
    SEL_MEM    = 3'd6,
    SEL_RSVD   = 3'd7
  } wb_sel_e;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wbu_state_e;

  typedef struct packed {
    logic alu;
    logic imme;
    logic pc;
    logic pc_seq;
    logic csr;
    logic mem;
  } wb_strb_t;

  // One-hot GPR write strobe for a select code; x0 and none/reserved write nothing.
  function automatic wb_strb_t sel_strobe(input wb_sel_e sel, input logic [REG_W-1:0] rd);
    wb_strb_t s;
    s = '0;
    if (rd != '0) begin
      case (sel)
        SEL_ALU:    s.alu    = 1'b1;
        SEL_IMME:   s.imme   = 1'b1;
        SEL_PC:     s.pc     = 1'b1;
        SEL_PC_SEQ: s.pc_seq = 1'b1;
        SEL_CSR:    s.csr    = 1'b1;
        SEL_MEM:    s.mem    = 1'b1;
        default:    s        = '0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/wbu_load_ext.sv
// Load data aligner: picks the byte/halfword at the access offset and sign- or
// zero-extends it according to the load funct3.
module wbu_load_ext
  import wbu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  lb_byte;
  logic [15:0] lh_half;

  always_comb begin
    lb_byte = 8'(rdata >> {addr_lo, 3'b000});
    lh_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){lb_byte[7]}}, lb_byte};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, lb_byte};
      F3_LH:   result = {{(XLEN-16){lh_half[15]}}, lh_half};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, lh_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wbu.sv
// Write-back unit: accepts one retiring instruction per cycle from EXU, waits for
// load data when needed, and drives registered one-hot GPR write strobes.
module wbu
  import wbu_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              wbu_rx_valid,
  output logic              wbu_rx_ready,
  input  logic [REG_W-1:0]  wbu_rx_rd_idx,
  input  logic [SEL_W-1:0]  wbu_rx_sel,
  input  logic [XLEN-1:0]   wbu_rx_exu_res,
  input  logic [XLEN-1:0]   wbu_rx_imme,
  input  logic [XLEN-1:0]   wbu_rx_pc,
  input  logic [XLEN-1:0]   wbu_rx_pc_seq,
  input  logic [XLEN-1:0]   wbu_rx_csr,
  input  logic [F3_W-1:0]   wbu_rx_ld_funct3,
  input  logic [1:0]        wbu_rx_ld_addr_lo,
  input  logic              wbu_mem_rvalid,
  input  logic [XLEN-1:0]   wbu_mem_rdata,
  input  logic              gpr_tx_ready,
  output logic [REG_W-1:0]  gpr_tx_rd_idx,
  output logic [XLEN-1:0]   gpr_tx_exu_res,
  output logic [XLEN-1:0]   gpr_tx_imme,
  output logic [XLEN-1:0]   gpr_tx_pc,
  output logic [XLEN-1:0]   gpr_tx_pc_seq,
  output logic [XLEN-1:0]   gpr_tx_csr,
  output logic [XLEN-1:0]   gpr_tx_mem,
  output logic              gpr_tx_alu_valid,
  output logic              gpr_tx_imme_valid,
  output logic              gpr_tx_pc_valid,
  output logic              gpr_tx_pc_seq_valid,
  output logic              gpr_tx_csr_valid,
  output logic              gpr_tx_mem_valid,
  output logic [CNT_W-1:0]  wbu_instret
);

  wbu_state_e      state, state_n, acc_state;
  wb_strb_t        strb, strb_n, acc_strb;
  wb_sel_e         rx_sel, sel_q;
  logic [F3_W-1:0] f3_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] mem_ext;
  logic            fire, done;

  assign rx_sel = wb_sel_e'(wbu_rx_sel);

  // Ready is gated by rstn so nothing is accepted while reset is held.
  assign wbu_rx_ready = rstn && ((state == ST_IDLE) || ((state == ST_WRITE) && gpr_tx_ready));
  assign fire         = wbu_rx_valid && wbu_rx_ready;
  assign done         = (state == ST_WRITE) && gpr_tx_ready;

  wbu_load_ext u_load_ext (
    .rdata   (wbu_mem_rdata),
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .result  (mem_ext)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      strb  <= '0;
    end else begin
      state <= state_n;
      strb  <= strb_n;
    end
  end

  always_comb begin
    state_n   = state;
    strb_n    = strb;
    acc_state = (rx_sel == SEL_MEM) ? ST_WAIT_MEM : ST_WRITE;
    acc_strb  = (rx_sel == SEL_MEM) ? wb_strb_t'('0) : sel_strobe(rx_sel, wbu_rx_rd_idx);
    case (state)
      ST_IDLE: begin
        if (fire) begin
          state_n = acc_state;
          strb_n  = acc_strb;
        end
      end
      ST_WAIT_MEM: begin
        if (wbu_mem_rvalid) begin
          state_n = ST_WRITE;
          strb_n  = sel_strobe(sel_q, gpr_tx_rd_idx);
        end
      end
      ST_WRITE: begin
        if (fire) begin
          state_n = acc_state;
          strb_n  = acc_strb;
        end else if (done) begin
          state_n = ST_IDLE;
          strb_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        strb_n  = '0;
      end
    endcase
  end

  // Payload capture on handshake, load result capture on first rvalid, retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpr_tx_rd_idx  <= '0;
      gpr_tx_exu_res <= '0;
      gpr_tx_imme    <= '0;
      gpr_tx_pc      <= '0;
      gpr_tx_pc_seq  <= '0;
      gpr_tx_csr     <= '0;
      gpr_tx_mem     <= '0;
      sel_q          <= SEL_NONE;
      f3_q           <= '0;
      lo_q           <= '0;
      wbu_instret    <= '0;
    end else begin
      if (fire) begin
        gpr_tx_rd_idx  <= wbu_rx_rd_idx;
        gpr_tx_exu_res <= wbu_rx_exu_res;
        gpr_tx_imme    <= wbu_rx_imme;
        gpr_tx_pc      <= wbu_rx_pc;
        gpr_tx_pc_seq  <= wbu_rx_pc_seq;
        gpr_tx_csr     <= wbu_rx_csr;
        sel_q          <= rx_sel;
        f3_q           <= wbu_rx_ld_funct3;
        lo_q           <= wbu_rx_ld_addr_lo;
      end
      if ((state == ST_WAIT_MEM) && wbu_mem_rvalid) begin
        gpr_tx_mem <= mem_ext;
      end
      if (done) begin
        wbu_instret <= wbu_instret + CNT_W'(1);
      end
    end
  end

  assign gpr_tx_alu_valid    = strb.alu;
  assign gpr_tx_imme_valid   = strb.imme;
  assign gpr_tx_pc_valid     = strb.pc;
  assign gpr_tx_pc_seq_valid = strb.pc_seq;
  assign gpr_tx_csr_valid    = strb.csr;
  assign gpr_tx_mem_valid    = strb.mem;

endmodule
